// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_pkg
// Description : Shared types for the instruction fetch unit. Holds the fetch
//               FSM state encoding, the error codes reported to decode, and a
//               helper that selects the 32-bit instruction from an 8-byte beat.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_fetch_pkg;

    // Instruction width delivered to decode
    localparam int c_INST_W = 32;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,   // present request to memory (or trap on misaligned PC)
        S_WAIT  = 2'd1,   // request accepted, waiting for read data
        S_OUT   = 2'd2,   // instruction held for decode
        S_DRAIN = 2'd3    // flushed while in flight, swallow the stale response
    } fetch_state_e;

    // Error code reported alongside each instruction
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_ACC  = 2'b01,
        ERR_MIS  = 2'b10
    } fetch_err_e;

    // Pick the instruction word out of an 8-byte aligned beat; PC bit 2
    // selects the upper word.
    function automatic logic [c_INST_W-1:0] select_word(
        input logic [63:0] data,
        input logic        hi
    );
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction fetch. Reads the PC from the branch unit, issues an
//               8-byte aligned read to instruction memory and hands the 32-bit
//               instruction to decode. Holds the PC register (o_pause) until
//               decode accepts. One fetch in flight.
// Ports       : i_clk, i_rst_n              clock, async active-low reset
//               i_pc, i_flush, o_pause      PC / branch unit interface
//               o_req_*, i_req_ready        memory read request
//               i_rsp_*                     memory read response
//               o_inst*, i_inst_ready       decode interface
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int XLEN  = 64,   // PC / address width
    parameter int BUS_W = 64    // memory read-data width, only 64 supported
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [XLEN-1:0]     i_pc,
    input  logic                i_flush,
    output logic                o_pause,
    output logic                o_req_valid,
    input  logic                i_req_ready,
    output logic [XLEN-1:0]     o_req_addr,
    input  logic                i_rsp_valid,
    input  logic [BUS_W-1:0]    i_rsp_data,
    input  logic                i_rsp_err,
    output logic                o_inst_valid,
    input  logic                i_inst_ready,
    output logic [c_INST_W-1:0] o_inst,
    output logic [XLEN-1:0]     o_inst_pc,
    output logic [1:0]          o_inst_err
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;

    // Goes high one cycle after reset release; keeps the request line quiet
    // while reset is asserted even though the FSM sits in S_REQ.
    logic                  r_run;

    logic [XLEN-1:0]       r_pc_q;
    logic [c_INST_W-1:0]   r_inst;
    fetch_err_e            r_inst_err;

    logic                  w_misaligned;
    logic                  w_req_valid;
    logic                  w_pc_we;
    logic                  w_out_we;
    logic [c_INST_W-1:0]   w_inst_d;
    fetch_err_e            w_err_d;

    assign w_misaligned = (i_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_REQ;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control. Flush has priority over every other event.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_pc_we     = 1'b0;
        w_out_we    = 1'b0;
        w_inst_d    = '0;
        w_err_d     = ERR_NONE;

        case (r_state)
            S_REQ: begin
                if (r_run && !i_flush) begin
                    if (w_misaligned) begin
                        // Report the fault directly, no bus access
                        w_pc_we     = 1'b1;
                        w_out_we    = 1'b1;
                        w_inst_d    = '0;
                        w_err_d     = ERR_MIS;
                        w_state_nxt = S_OUT;
                    end else begin
                        w_req_valid = 1'b1;
                        if (i_req_ready) begin
                            w_pc_we     = 1'b1;
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (i_flush) begin
                    // A response arriving with the flush is simply dropped
                    w_state_nxt = i_rsp_valid ? S_REQ : S_DRAIN;
                end else if (i_rsp_valid) begin
                    w_out_we    = 1'b1;
                    w_inst_d    = select_word(i_rsp_data, r_pc_q[2]);
                    w_err_d     = i_rsp_err ? ERR_ACC : ERR_NONE;
                    w_state_nxt = S_OUT;
                end
            end

            S_OUT: begin
                if (i_flush || i_inst_ready) begin
                    w_state_nxt = S_REQ;
                end
            end

            S_DRAIN: begin
                // A further flush changes nothing here; the stale response
                // is still the one event that ends the drain.
                if (i_rsp_valid) begin
                    w_state_nxt = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers (write-enabled flops)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc_q <= '0;
        end else if (w_pc_we) begin
            r_pc_q <= i_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inst     <= '0;
            r_inst_err <= ERR_NONE;
        end else if (w_out_we) begin
            r_inst     <= w_inst_d;
            r_inst_err <= w_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_req_valid  = w_req_valid;
    assign o_req_addr   = {i_pc[XLEN-1:3], 3'b000};
    assign o_inst_valid = (r_state == S_OUT);
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_pc_q;
    assign o_inst_err   = r_inst_err;

    // The PC may advance only on a real, unflushed hand-off to decode
    assign o_pause = !((r_state == S_OUT) && i_inst_ready && !i_flush);

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch. Expected instructions are
//               queued when the memory response (or misaligned trap) is
//               driven and popped when decode accepts the instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    logic        i_clk;
    logic        i_rst_n;
    logic [63:0] i_pc;
    logic        i_flush;
    logic        o_pause;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [63:0] o_req_addr;
    logic        i_rsp_valid;
    logic [63:0] i_rsp_data;
    logic        i_rsp_err;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [63:0] o_inst_pc;
    logic [1:0]  o_inst_err;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [1:0]  err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ifu_fetch #(.XLEN(64), .BUS_W(64)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pc         (i_pc),
        .i_flush      (i_flush),
        .o_pause      (o_pause),
        .o_req_valid  (o_req_valid),
        .i_req_ready  (i_req_ready),
        .o_req_addr   (o_req_addr),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_data   (i_rsp_data),
        .i_rsp_err    (i_rsp_err),
        .o_inst_valid (o_inst_valid),
        .i_inst_ready (i_inst_ready),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_inst_err   (o_inst_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk_exp(input logic [31:0] inst, input logic [63:0] pc,
                                    input logic [1:0] err);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        e.err  = err;
        return e;
    endfunction

    // ---------------- drivers (observe, never judge) ----------------
    // All drivers start and end on a falling clock edge.
    task automatic issue(input logic [63:0] pc, output logic seen,
                         output logic [63:0] addr, output logic pause);
        i_pc        = pc;
        i_req_ready = 1'b1;
        #1;
        seen  = o_req_valid;
        addr  = o_req_addr;
        pause = o_pause;
        @(negedge i_clk);
        i_req_ready = 1'b0;
    endtask

    task automatic respond(input int lat, input logic [63:0] data, input logic err);
        repeat (lat) @(negedge i_clk);
        i_rsp_valid = 1'b1;
        i_rsp_data  = data;
        i_rsp_err   = err;
        @(negedge i_clk);
        i_rsp_valid = 1'b0;
        i_rsp_data  = '0;
        i_rsp_err   = 1'b0;
    endtask

    task automatic accept(output exp_t got, output logic valid, output logic pause);
        i_inst_ready = 1'b1;
        #1;
        valid = o_inst_valid;
        pause = o_pause;
        got   = mk_exp(o_inst, o_inst_pc, o_inst_err);
        @(negedge i_clk);
        i_inst_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        i_pc = 64'h8000_0000; i_flush = 0; i_req_ready = 1; i_rsp_valid = 0;
        i_rsp_data = '0; i_rsp_err = 0; i_inst_ready = 0;
        repeat (3) @(negedge i_clk);
        #1;
        checks++;
        if ({o_req_valid, o_inst_valid, o_pause} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b val=%b pause=%b exp 0 0 1",
                     o_req_valid, o_inst_valid, o_pause);
        end
        checks++;
        if ({o_inst, o_inst_pc, o_inst_err} !== '0) begin
            errors++;
            $display("FAIL reset_data got inst=%h pc=%h err=%b exp zeros",
                     o_inst, o_inst_pc, o_inst_err);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1; i_req_ready = 0;
        @(negedge i_clk);
    endtask

    task automatic test_basic();
        logic seen, pz, v; logic [63:0] addr; exp_t got, e;
        issue(64'h8000_0000, seen, addr, pz);
        checks++;
        if (seen !== 1'b1 || addr !== 64'h8000_0000 || pz !== 1'b1) begin
            errors++;
            $display("FAIL basic_req got v=%b addr=%h pause=%b exp 1 80000000 1", seen, addr, pz);
        end
        exp_q.push_back(mk_exp(32'h0010_0093, 64'h8000_0000, 2'b00));
        respond(0, 64'h0000_0013_0010_0093, 1'b0);
        accept(got, v, pz);
        e = exp_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== e || pz !== 1'b0) begin
            errors++;
            $display("FAIL basic_inst got v=%b %h pause=%b exp 1 %h 0", v, got, pz, e);
        end
        #1;
        checks++;
        if (o_pause !== 1'b1 || o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_after got pause=%b val=%b exp 1 0", o_pause, o_inst_valid);
        end
    endtask

    task automatic test_upper_word();
        logic seen, pz, v; logic [63:0] addr; exp_t got, e;
        issue(64'h8000_0004, seen, addr, pz);
        checks++;
        if (seen !== 1'b1 || addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL upper_req got v=%b addr=%h exp 1 80000000", seen, addr);
        end
        exp_q.push_back(mk_exp(32'h0000_0013, 64'h8000_0004, 2'b00));
        respond(0, 64'h0000_0013_0010_0093, 1'b0);
        accept(got, v, pz);
        e = exp_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL upper_inst got v=%b %h exp 1 %h", v, got, e);
        end
    endtask

    task automatic test_stall();
        logic seen, pz, v; logic [63:0] addr; exp_t got, e;
        issue(64'h8000_000C, seen, addr, pz);
        exp_q.push_back(mk_exp(32'hCAFE_0001, 64'h8000_000C, 2'b00));
        respond(2, 64'hCAFE_0001_1234_5678, 1'b0);
        e = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (o_inst_valid !== 1'b1 || o_inst !== e.inst || o_inst_pc !== e.pc ||
                o_pause !== 1'b1 || o_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got val=%b inst=%h pc=%h pause=%b req=%b exp 1 %h %h 1 0",
                         k, o_inst_valid, o_inst, o_inst_pc, o_pause, o_req_valid, e.inst, e.pc);
            end
            @(negedge i_clk);
        end
        accept(got, v, pz);
        e = exp_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== e || pz !== 1'b0) begin
            errors++;
            $display("FAIL stall_inst got v=%b %h pause=%b exp 1 %h 0", v, got, pz, e);
        end
    endtask

    task automatic test_flush_wait();
        logic seen, pz, v; logic [63:0] addr; exp_t got, e;
        issue(64'h8000_0010, seen, addr, pz);
        i_flush = 1'b1; i_pc = 64'h8000_0100;
        #1;
        checks++;
        if (o_pause !== 1'b1 || o_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushw_flush got pause=%b req=%b exp 1 0", o_pause, o_req_valid);
        end
        @(negedge i_clk);
        i_flush = 1'b0;
        #1;
        checks++;
        if (o_req_valid !== 1'b0 || o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushw_drain1 got req=%b val=%b exp 0 0", o_req_valid, o_inst_valid);
        end
        @(negedge i_clk);
        i_rsp_valid = 1'b1; i_rsp_data = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        checks++;
        if (o_req_valid !== 1'b0 || o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL flushw_drain2 got req=%b val=%b exp 0 0", o_req_valid, o_inst_valid);
        end
        @(negedge i_clk);
        i_rsp_valid = 1'b0; i_rsp_data = '0;
        #1;
        checks++;
        if (o_inst_valid !== 1'b0 || o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0100) begin
            errors++;
            $display("FAIL flushw_redirect got val=%b req=%b addr=%h exp 0 1 80000100",
                     o_inst_valid, o_req_valid, o_req_addr);
        end
        issue(64'h8000_0100, seen, addr, pz);
        exp_q.push_back(mk_exp(32'h1111_2222, 64'h8000_0100, 2'b00));
        respond(1, 64'h3333_4444_1111_2222, 1'b0);
        accept(got, v, pz);
        e = exp_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL flushw_inst got v=%b %h exp 1 %h", v, got, e);
        end
    endtask

    task automatic test_flush_races();
        logic seen, pz, v; logic [63:0] addr; exp_t got, e;
        // Flush together with the response in S_WAIT
        issue(64'h8000_0020, seen, addr, pz);
        i_flush = 1'b1; i_rsp_valid = 1'b1; i_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        i_pc = 64'h8000_0028;
        @(negedge i_clk);
        i_flush = 1'b0; i_rsp_valid = 1'b0; i_rsp_data = '0;
        #1;
        checks++;
        if (o_inst_valid !== 1'b0 || o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0028) begin
            errors++;
            $display("FAIL race_wait got val=%b req=%b addr=%h exp 0 1 80000028",
                     o_inst_valid, o_req_valid, o_req_addr);
        end
        // Flush together with decode ready in S_OUT: flush wins
        issue(64'h8000_0028, seen, addr, pz);
        respond(0, 64'h5555_6666_7777_8888, 1'b0);
        i_flush = 1'b1; i_inst_ready = 1'b1; i_pc = 64'h8000_0200;
        #1;
        checks++;
        if (o_pause !== 1'b1) begin
            errors++;
            $display("FAIL race_out_pause got %b exp 1", o_pause);
        end
        @(negedge i_clk);
        i_flush = 1'b0; i_inst_ready = 1'b0;
        #1;
        checks++;
        if (o_inst_valid !== 1'b0 || o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0200) begin
            errors++;
            $display("FAIL race_out_redirect got val=%b req=%b addr=%h exp 0 1 80000200",
                     o_inst_valid, o_req_valid, o_req_addr);
        end
        issue(64'h8000_0200, seen, addr, pz);
        exp_q.push_back(mk_exp(32'h0badc0de, 64'h8000_0200, 2'b00));
        respond(0, 64'hFFFF_FFFF_0BAD_C0DE, 1'b0);
        accept(got, v, pz);
        e = exp_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL race_inst got v=%b %h exp 1 %h", v, got, e);
        end
    endtask

    task automatic test_misaligned();
        logic seen, pz, v; logic [63:0] addr; exp_t got, e;
        issue(64'h8000_0002, seen, addr, pz);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mis_req got req=%b exp 0", seen);
        end
        exp_q.push_back(mk_exp(32'h0, 64'h8000_0002, 2'b10));
        accept(got, v, pz);
        e = exp_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== e || pz !== 1'b0) begin
            errors++;
            $display("FAIL mis_inst got v=%b %h pause=%b exp 1 %h 0", v, got, pz, e);
        end
    endtask

    task automatic test_access_err();
        logic seen, pz, v; logic [63:0] addr; exp_t got, e;
        issue(64'h8000_0030, seen, addr, pz);
        exp_q.push_back(mk_exp(32'h9ABC_DEF0, 64'h8000_0030, 2'b01));
        respond(1, 64'h1234_5678_9ABC_DEF0, 1'b1);
        accept(got, v, pz);
        e = exp_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL acc_err got v=%b %h exp 1 %h", v, got, e);
        end
    endtask

    task automatic test_reset_wait();
        logic seen, pz, v; logic [63:0] addr; exp_t got, e;
        issue(64'h8000_0040, seen, addr, pz);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_inst_valid !== 1'b0 || o_pause !== 1'b1 || o_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstw_during got val=%b pause=%b req=%b exp 0 1 0",
                     o_inst_valid, o_pause, o_req_valid);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1; i_pc = 64'h8000_0048;
        @(negedge i_clk);
        #1;
        checks++;
        if (o_req_valid !== 1'b1 || o_req_addr !== 64'h8000_0048 || o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstw_fresh got req=%b addr=%h val=%b exp 1 80000048 0",
                     o_req_valid, o_req_addr, o_inst_valid);
        end
        issue(64'h8000_0048, seen, addr, pz);
        exp_q.push_back(mk_exp(32'h4848_4848, 64'h8000_0048, 2'b00));
        respond(0, 64'h0000_0001_4848_4848, 1'b0);
        accept(got, v, pz);
        e = exp_q.pop_front();
        checks++;
        if (v !== 1'b1 || got !== e) begin
            errors++;
            $display("FAIL rstw_inst got v=%b %h exp 1 %h", v, got, e);
        end
    endtask

    task automatic test_back_to_back();
        logic seen, pz, v; logic [63:0] addr, pc, data; exp_t got, e;
        for (int k = 0; k < 6; k++) begin
            pc   = 64'h8000_1000 + 64'(4 * k);
            data = {$urandom, $urandom};
            issue(pc, seen, addr, pz);
            checks++;
            if (seen !== 1'b1 || addr !== (pc & ~64'h7)) begin
                errors++;
                $display("FAIL b2b_req[%0d] got v=%b addr=%h exp 1 %h", k, seen, addr, pc & ~64'h7);
            end
            exp_q.push_back(mk_exp(pc[2] ? data[63:32] : data[31:0], pc, 2'b00));
            respond(int'($urandom_range(0, 2)), data, 1'b0);
            accept(got, v, pz);
            e = exp_q.pop_front();
            checks++;
            if (v !== 1'b1 || got !== e || pz !== 1'b0) begin
                errors++;
                $display("FAIL b2b_inst[%0d] got v=%b %h pause=%b exp 1 %h 0", k, v, got, pz, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_upper_word();
        test_stall();
        test_flush_wait();
        test_flush_races();
        test_misaligned();
        test_access_err();
        test_reset_wait();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d entries exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
